// File: rtl/noc_input_port_buffer_if.sv
// Handshake/bus bundle between the NoC input port buffer and its neighbours.
interface noc_input_port_buffer_if #(
    parameter int unsigned FLIT_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COORD_W = 4
);
    logic [FLIT_W-1:0]        in_flit;
    logic [1:0]               in_type;
    logic                     in_valid;
    logic                     in_ready;
    logic [COORD_W-1:0]       rc_dest_x;
    logic [COORD_W-1:0]       rc_dest_y;
    logic [2:0]               rc_port;
    logic [FLIT_W-1:0]        out_flit;
    logic [1:0]               out_type;
    logic                     out_valid;
    logic [2:0]               out_port;
    logic                     sa_grant;
    logic                     err_drop;
    logic [$clog2(DEPTH):0]   occupancy;

    // Environment side: upstream link, route compute and switch allocator.
    modport master (
        output in_flit, in_type, in_valid, rc_port, sa_grant,
        input  in_ready, rc_dest_x, rc_dest_y, out_flit, out_type,
               out_valid, out_port, err_drop, occupancy
    );

    // Buffer side.
    modport slave (
        input  in_flit, in_type, in_valid, rc_port, sa_grant,
        output in_ready, rc_dest_x, rc_dest_y, out_flit, out_type,
               out_valid, out_port, err_drop, occupancy
    );
endinterface

// File: rtl/noc_input_port_buffer.sv
// NoC router input port: flit FIFO, per-packet route latch, and streaming
// toward the switch allocator. Malformed traffic is discarded with err_drop.
module noc_input_port_buffer #(
    parameter int unsigned FLIT_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned NUM_PORTS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    noc_input_port_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_ACTIVE,
        ST_DROP
    } state_t;

    logic [FLIT_W-1:0] mem_flit_q [DEPTH];
    logic [1:0]        mem_type_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic [2:0]        out_port_q, out_port_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              err_drop_q, err_drop_d;

    logic              push;
    logic              pop;
    logic [FLIT_W-1:0] front_flit;
    logic [1:0]        front_type;
    logic              front_is_head;
    logic              front_is_tail;
    logic              fifo_empty;
    logic              rc_legal;

    // Show-ahead view of the FIFO front entry.
    assign front_flit    = mem_flit_q[rd_ptr_q];
    assign front_type    = mem_type_q[rd_ptr_q];
    assign front_is_head = front_type[0];
    assign front_is_tail = front_type[1];
    assign fifo_empty    = (count_q == '0);
    assign rc_legal      = (32'(bus.rc_port) < NUM_PORTS);

    // Next-state, FIFO pointer and handshake computation.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_port_d = out_port_q;
        err_drop_d = 1'b0;
        pop        = 1'b0;
        push       = bus.in_valid & in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (front_is_head) begin
                        state_d = ST_ROUTE;
                    end else begin
                        // orphan body/tail flit
                        pop        = 1'b1;
                        err_drop_d = 1'b1;
                    end
                end
            end
            ST_ROUTE: begin
                if (rc_legal) begin
                    out_port_d = bus.rc_port;
                    state_d    = ST_ACTIVE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_ACTIVE: begin
                if (out_valid_q && bus.sa_grant) begin
                    pop = 1'b1;
                    if (front_is_tail) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    err_drop_d = 1'b1;
                    if (front_is_tail) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        // Registered handshakes track the post-edge count and state.
        in_ready_d  = (count_d != CNT_W'(DEPTH));
        out_valid_d = (state_d == ST_ACTIVE) && (count_d != '0);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_port_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_port_q  <= out_port_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_drop_q  <= err_drop_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_flit_q[wr_ptr_q] <= bus.in_flit;
            mem_type_q[wr_ptr_q] <= bus.in_type;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rc_dest_x = front_flit[COORD_W-1:0];
    assign bus.rc_dest_y = front_flit[2*COORD_W-1:COORD_W];
    assign bus.out_flit  = front_flit;
    assign bus.out_type  = front_type;
    assign bus.out_valid = out_valid_q;
    assign bus.out_port  = out_port_q;
    assign bus.err_drop  = err_drop_q;
    assign bus.occupancy = count_q;

endmodule

// File: tb/tb_noc_input_port_buffer.sv
// Bench for noc_input_port_buffer: queue-based packet model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_noc_input_port_buffer;
    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned COORD_W   = 4;
    localparam int unsigned NUM_PORTS = 5;

    logic clk;
    logic rst;

    noc_input_port_buffer_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .COORD_W(COORD_W)) bus ();

    noc_input_port_buffer #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .COORD_W(COORD_W), .NUM_PORTS(NUM_PORTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Route compute stand-in: port = low 3 bits of destination y.
    assign bus.rc_port = bus.rc_dest_y[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] flit;
        logic [1:0]  t;
    } ent_t;

    typedef enum {M_WAIT, M_ROUTING, M_FWD, M_DISCARD} mmode_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    ent_t   mq[$];
    ent_t   stim[$];
    mmode_t m_mode;
    int     m_port;
    bit     m_err;
    bit     m_started;
    int     m_tails;
    int     dut_tails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode    = M_WAIT;
        m_port    = 0;
        m_err     = 1'b0;
        m_started = 1'b0;
    endtask

    function automatic bit model_can_push();
        return m_started && (mq.size() != DEPTH);
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic check_outputs();
        int occ;
        occ = mq.size();
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, model_can_push()});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, (m_mode == M_FWD) && (occ > 0)});
        chk("occupancy", 32'(bus.occupancy), occ);
        chk("out_port", 32'(bus.out_port), m_port);
        chk("err_drop", {31'b0, bus.err_drop}, {31'b0, m_err});
        if (occ > 0) begin
            chk("out_flit", bus.out_flit, mq[0].flit);
            chk("out_type", 32'(bus.out_type), 32'(mq[0].t));
            chk("rc_dest_x", 32'(bus.rc_dest_x), 32'(mq[0].flit[3:0]));
            chk("rc_dest_y", 32'(bus.rc_dest_y), 32'(mq[0].flit[7:4]));
        end
    endtask

    // Advance the packet model by one clock using the inputs now applied.
    task automatic model_advance();
        bit   push;
        bit   pop;
        bit   err;
        int   p;
        ent_t e;
        push = bus.in_valid && model_can_push();
        pop  = 1'b0;
        err  = 1'b0;
        case (m_mode)
            M_WAIT: begin
                if (mq.size() > 0) begin
                    if (mq[0].t == 2'b01 || mq[0].t == 2'b11) m_mode = M_ROUTING;
                    else begin pop = 1'b1; err = 1'b1; end
                end
            end
            M_ROUTING: begin
                p = int'(mq[0].flit[6:4]);
                if (p < NUM_PORTS) begin m_port = p; m_mode = M_FWD; end
                else m_mode = M_DISCARD;
            end
            M_FWD: begin
                if (mq.size() > 0 && bus.sa_grant) begin
                    pop = 1'b1;
                    if (mq[0].t == 2'b10 || mq[0].t == 2'b11) begin
                        m_mode = M_WAIT;
                        m_tails++;
                    end
                end
            end
            M_DISCARD: begin
                if (mq.size() > 0) begin
                    pop = 1'b1;
                    err = 1'b1;
                    if (mq[0].t == 2'b10 || mq[0].t == 2'b11) m_mode = M_WAIT;
                end
            end
            default: m_mode = M_WAIT;
        endcase
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.flit = bus.in_flit;
            e.t    = bus.in_type;
            mq.push_back(e);
        end
        m_err     = err;
        m_started = 1'b1;
    endtask

    // One clock: check at the falling edge, advance the model, cross the edge.
    task automatic step();
        check_outputs();
        if (bus.out_valid && bus.sa_grant && bus.out_type[1]) dut_tails++;
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] f);
        bus.in_valid = v;
        bus.in_type  = t;
        bus.in_flit  = f;
    endtask

    task automatic gen_packet();
        int   len;
        ent_t e;
        if ($urandom_range(0, 15) == 0) begin
            e.flit = $urandom;
            e.t    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
            stim.push_back(e);
        end else begin
            len = $urandom_range(1, 5);
            if (len == 1) begin
                e.flit = $urandom; e.t = 2'b11; stim.push_back(e);
            end else begin
                e.flit = $urandom; e.t = 2'b01; stim.push_back(e);
                for (int i = 0; i < len - 2; i++) begin
                    e.flit = $urandom; e.t = 2'b00; stim.push_back(e);
                end
                e.flit = $urandom; e.t = 2'b10; stim.push_back(e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e_cnt;
        int  v_cnt;
        bit  acc;
        m_tails   = 0;
        dut_tails = 0;
        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0);
        bus.sa_grant = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_occupancy", 32'(bus.occupancy), 0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
        chk("rst_out_port", 32'(bus.out_port), 0);
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", {31'b0, bus.in_ready}, 1);

        // Single-flit packet routed to port 2.
        drive(1'b1, 2'b11, 32'h0000_0023);
        step();
        drive(1'b0, 2'b00, 32'h0);
        step();
        chk("single_dest_x", 32'(bus.rc_dest_x), 3);
        chk("single_dest_y", 32'(bus.rc_dest_y), 2);
        step();
        chk("single_out_valid", {31'b0, bus.out_valid}, 1);
        chk("single_out_port", 32'(bus.out_port), 2);
        bus.sa_grant = 1'b1;
        step();
        bus.sa_grant = 1'b0;
        chk("single_occ_after_pop", 32'(bus.occupancy), 0);
        chk("single_ov_after_pop", {31'b0, bus.out_valid}, 0);
        step();

        // Four-flit packet fills the FIFO; full push attempt during a pop.
        drive(1'b1, 2'b01, 32'h0000_0011); step();
        drive(1'b1, 2'b00, 32'hB0D1_0001); step();
        drive(1'b1, 2'b00, 32'hB0D2_0002); step();
        drive(1'b1, 2'b10, 32'h7A11_0003); step();
        chk("full_in_ready", {31'b0, bus.in_ready}, 0);
        chk("full_occupancy", 32'(bus.occupancy), 4);
        chk("full_out_port", 32'(bus.out_port), 1);
        drive(1'b1, 2'b00, 32'hDEAD_BEEF);
        bus.sa_grant = 1'b1;
        step();
        chk("full_pop_no_push", 32'(bus.occupancy), 3);
        drive(1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("burst_out_valid", {31'b0, bus.out_valid}, 1);
            chk("burst_out_port", 32'(bus.out_port), 1);
            step();
        end
        chk("burst_occ_end", 32'(bus.occupancy), 0);
        chk("burst_ov_end", {31'b0, bus.out_valid}, 0);
        bus.sa_grant = 1'b0;

        // Orphan body flit.
        e_cnt = 0; v_cnt = 0;
        drive(1'b1, 2'b00, 32'h0000_0042); step();
        drive(1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            e_cnt += int'(bus.err_drop);
            v_cnt += int'(bus.out_valid);
        end
        chk("orphan_err_pulses", e_cnt, 1);
        chk("orphan_out_valid", v_cnt, 0);

        // Illegal route (port 6): whole packet discarded.
        e_cnt = 0; v_cnt = 0;
        bus.sa_grant = 1'b1;
        drive(1'b1, 2'b01, 32'h0000_0060); step();
        e_cnt += int'(bus.err_drop); v_cnt += int'(bus.out_valid);
        drive(1'b1, 2'b00, 32'h1111_1111); step();
        e_cnt += int'(bus.err_drop); v_cnt += int'(bus.out_valid);
        drive(1'b1, 2'b10, 32'h2222_2222); step();
        e_cnt += int'(bus.err_drop); v_cnt += int'(bus.out_valid);
        drive(1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            e_cnt += int'(bus.err_drop);
            v_cnt += int'(bus.out_valid);
        end
        chk("drop_err_pulses", e_cnt, 3);
        chk("drop_out_valid", v_cnt, 0);
        chk("drop_occ_end", 32'(bus.occupancy), 0);
        bus.sa_grant = 1'b0;

        // Reset while a packet is active with three flits buffered.
        drive(1'b1, 2'b01, 32'h0000_0031); step();
        drive(1'b1, 2'b00, 32'h3333_0001); step();
        drive(1'b1, 2'b00, 32'h3333_0002); step();
        drive(1'b0, 2'b00, 32'h0);
        chk("pre_rst_occ", 32'(bus.occupancy), 3);
        chk("pre_rst_ov", {31'b0, bus.out_valid}, 1);
        rst = 1'b1;
        #1;
        chk("midrst_occ", 32'(bus.occupancy), 0);
        chk("midrst_ov", {31'b0, bus.out_valid}, 0);
        chk("midrst_err", {31'b0, bus.err_drop}, 0);
        chk("midrst_port", 32'(bus.out_port), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random packet traffic with back-pressure.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stim.size() < 2) gen_packet();
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_flit  = stim[0].flit;
            bus.in_type  = stim[0].t;
            bus.sa_grant = ($urandom_range(0, 9) < 7);
            acc = bus.in_valid && model_can_push();
            step();
            if (acc) void'(stim.pop_front());
        end
        chk("tails_forwarded", dut_tails, m_tails);
        chk("enough_packets", {31'b0, m_tails >= 10}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_input_port_buffer.md
Name: noc_input_port_buffer

Overview:
- Per-port input stage of the NoC router; sits directly upstream of the combinational route-compute/arbitration block.
- Buffers incoming flits in a small FIFO and presents the head flit's destination coordinates to route compute.
- Latches the returned output-port decision for the whole packet, then streams the packet's flits toward the switch allocator/crossbar with a valid/grant handshake.
- Drops malformed traffic: an orphan body/tail flit, or a packet routed to a nonexistent port.

Parameters:
FLIT_W, 32, flit payload width in bits
DEPTH, 4, FIFO entries (power of two, >= 2)
COORD_W, 4, width of each destination coordinate carried in head-flit payload bits [2*COORD_W-1:0] (x in low half)
NUM_PORTS, 5, number of legal output ports; port codes 0..NUM_PORTS-1 are valid

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_flit  in  FLIT_W  incoming flit payload
in_type  in  2  flit type: 00 body, 01 head, 10 tail, 11 head+tail (single-flit packet)
in_valid  in  1  upstream presents a flit
in_ready  out  1  buffer can accept; push occurs when in_valid & in_ready
rc_dest_x  out  COORD_W  destination x of the front flit (payload[COORD_W-1:0])
rc_dest_y  out  COORD_W  destination y of the front flit (payload[2*COORD_W-1:COORD_W])
rc_port  in  3  combinational route-compute result for rc_dest_x/y
out_flit  out  FLIT_W  front flit payload
out_type  out  2  front flit type
out_valid  out  1  request to switch allocator for port out_port
out_port  out  3  latched output port of the current packet
sa_grant  in  1  allocator/crossbar accepts; pop occurs when out_valid & sa_grant
err_drop  out  1  one-cycle pulse per flit discarded
occupancy  out  $clog2(DEPTH)+1  current FIFO count

Behaviour:
- Reset (asynchronous, immediate): FIFO empty, rd/wr pointers 0, state IDLE, out_port 0, err_drop 0, out_valid 0, occupancy 0. in_ready becomes 1 on the first clock after rst deasserts.
- FIFO:
  - in_ready = (count != DEPTH); no write-when-full, even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - out_flit/out_type/rc_dest_* are driven from the FIFO front entry (show-ahead).
- States: IDLE, ROUTE, ACTIVE, DROP.
  - IDLE, FIFO empty: stay.
  - IDLE, front is head or head+tail: go to ROUTE.
  - IDLE, front is body or tail: pop it, pulse err_drop, stay IDLE (orphan flit).
  - ROUTE: exactly one cycle. Sample rc_port.
    - rc_port < NUM_PORTS: load out_port, go to ACTIVE.
    - Otherwise: go to DROP (out_port unchanged).
  - ACTIVE: out_valid = FIFO nonempty. On out_valid & sa_grant, pop the front.
    - If the popped flit type is tail or head+tail, go to IDLE.
    - Else stay ACTIVE; out_port is held for the whole packet.
  - DROP: out_valid = 0. Pop one flit per cycle while nonempty; pulse err_drop per pop. Popping a tail or head+tail flit returns to IDLE.
- out_valid is 0 in IDLE, ROUTE and DROP.
- ACTIVE with FIFO empty mid-packet: out_valid = 0; wait, no timeout.
- A head flit arriving while ACTIVE/DROP is treated as an ordinary flit of the current packet (no packet abort).
- Latency: a head flit pushed into an empty buffer on edge E0 → state ROUTE after E1, ACTIVE with out_valid=1 after E2. Minimum 2 cycles push-to-request. Steady-state throughput is 1 flit/cycle with sa_grant held high.
- Back-to-back packets: after a tail pop at edge Ek, a following head goes IDLE→ROUTE→ACTIVE. This is a 2-cycle bubble per packet (accepted cost).
- Reset mid-packet: all state cleared asynchronously; flits in the FIFO are lost; no err_drop pulse.
- rc_port is only sampled in ROUTE; its value in other states is ignored.

Test Plan:
- Single-flit packet: push type 11, payload 0x0000_0023 with rc_port=2 → rc_dest_x=3, rc_dest_y=2; out_valid=1, out_port=2 two cycles after push; grant → pop, state IDLE, occupancy 0.
- 4-flit packet (head, body, body, tail), DEPTH=4, sa_grant=0 → in_ready drops to 0 after 4th push. Raise sa_grant → 4 consecutive pops, one per cycle, out_port constant, IDLE after tail.
- Orphan body flit pushed into empty buffer → popped in IDLE, err_drop pulses once, out_valid never asserts.
- Head with rc_port=6 (NUM_PORTS=5) followed by body and tail → DROP state, 3 err_drop pulses total, out_valid stays 0, returns to IDLE.
- Full FIFO with in_valid=1 and pop in the same cycle → no push accepted that cycle; count goes 4→3. Pointer wrap verified over 10 packets with payload integrity.
- Assert rst while ACTIVE with 3 flits buffered → occupancy=0, out_valid=0, state IDLE immediately (before the next clock edge).
